// File: rtl/evtcap_pkg.sv
`default_nettype none
// ============================================================================
// Module : evtcap_pkg - shared types/helpers for bitbus_event_capture
// Rev    : 1.0
// ============================================================================
package evtcap_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    OVERFLOW = 2'd2
  } evtcap_state_t;

  localparam int EVTCAP_DEF_WIDTH    = 4;
  localparam int EVTCAP_DEF_TS_WIDTH = 32;
  localparam int EVTCAP_DROP_W       = 16;

  // Record layout at the default configuration; same "TS VAL" row order as the vector files.
  typedef struct packed {
    logic [EVTCAP_DEF_TS_WIDTH-1:0] ts;
    logic [EVTCAP_DEF_WIDTH-1:0]    bits;
  } evtcap_rec_t;

  function automatic int evtcap_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bitbus_event_capture_if.sv
`default_nettype none
// ============================================================================
// Module : bitbus_event_capture_if - valid/ready record stream
// Rev    : 1.0
// ============================================================================
interface bitbus_event_capture_if #(
  parameter int WIDTH    = 4,
  parameter int TS_WIDTH = 32
);
  logic                evt_valid;
  logic                evt_ready;
  logic [TS_WIDTH-1:0] evt_ts;
  logic [WIDTH-1:0]    evt_bits;

  modport master (output evt_valid, output evt_ts, output evt_bits, input evt_ready);
  modport slave  (input evt_valid, input evt_ts, input evt_bits, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/evtcap_fifo.sv
`default_nettype none
// ============================================================================
// Module : evtcap_fifo - synchronous first-word-fall-through record FIFO
// Rev    : 1.0
// ============================================================================
module evtcap_fifo
  import evtcap_pkg::*;
#(
  parameter int DATA_W = 36,
  parameter int DEPTH  = 16
) (
  input  wire logic                         clk_i,
  input  wire logic                         rst_n_i,
  input  wire logic                         push_i,
  input  wire logic [DATA_W-1:0]            wdata_i,
  input  wire logic                         pop_i,
  output logic      [DATA_W-1:0]            rdata_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic      [evtcap_ptr_w(DEPTH):0] count_o
);

  localparam int                PTR_W      = evtcap_ptr_w(DEPTH);
  localparam logic [PTR_W:0]    c_full_cnt = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              w_do_push;
  logic              w_do_pop;

  assign full_o    = (count_q == c_full_cnt);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign w_do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign rdata_o   = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (w_do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bitbus_event_capture.sv
`default_nettype none
// ============================================================================
// Module : bitbus_event_capture - timestamped change-event recorder for bus bits
//          Define EVTCAP_DROP_COUNT_EN to add the saturating dropped_o counter.
// Rev    : 1.0
// ============================================================================
module bitbus_event_capture
  import evtcap_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int TS_WIDTH   = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  wire logic                              clk_i,
  input  wire logic                              rst_n_i,
  input  wire logic                              enable_i,
  input  wire logic [WIDTH-1:0]                  bits_i,
  bitbus_event_capture_if.master                 evt_if,
  output logic      [evtcap_ptr_w(FIFO_DEPTH):0] count_o,
  output logic                                   overflow_o
`ifdef EVTCAP_DROP_COUNT_EN
  ,
  output logic      [EVTCAP_DROP_W-1:0]          dropped_o
`endif
);

  typedef struct packed {
    logic [TS_WIDTH-1:0] ts;
    logic [WIDTH-1:0]    bits;
  } rec_t;

  logic                en_q, en_d;
  logic [WIDTH-1:0]    bits_q, bits_d;
  logic [WIDTH-1:0]    bits_prev_q, bits_prev_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  evtcap_state_t       state_q, state_d;
  logic                overflow_q, overflow_d;

  logic                w_change;
  logic                w_push_req;
  logic                w_lost;
  logic                w_fifo_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  rec_t                w_wr_rec;
  rec_t                w_rd_rec;

  assign w_change = (bits_q != bits_prev_q);
  assign w_pop    = !w_empty && evt_if.evt_ready;
  assign w_wr_rec = '{ts: ts_q, bits: bits_q};

  always_comb begin
    en_d        = enable_i;
    bits_d      = bits_i;
    bits_prev_d = bits_q;
    ts_d        = en_q ? ts_q + 1'b1 : '0;
    state_d     = state_q;
    overflow_d  = overflow_q;
    w_push_req  = 1'b0;
    w_lost      = 1'b0;
    w_fifo_push = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_q) begin
          state_d    = CAPTURE;
          overflow_d = 1'b0;
          w_push_req = 1'b1;
        end
      end
      CAPTURE: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (w_change) begin
          w_push_req = 1'b1;
        end
      end
      OVERFLOW: begin
        if (!en_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    w_lost      = w_push_req && w_full && !w_pop;
    w_fifo_push = w_push_req && !w_lost;
    if (w_lost) begin
      overflow_d = 1'b1;
      state_d    = OVERFLOW;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      en_q        <= 1'b0;
      bits_q      <= '0;
      bits_prev_q <= '0;
      ts_q        <= '0;
      state_q     <= IDLE;
      overflow_q  <= 1'b0;
    end else begin
      en_q        <= en_d;
      bits_q      <= bits_d;
      bits_prev_q <= bits_prev_d;
      ts_q        <= ts_d;
      state_q     <= state_d;
      overflow_q  <= overflow_d;
    end
  end

  evtcap_fifo #(
    .DATA_W (TS_WIDTH + WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (w_fifo_push),
    .wdata_i (w_wr_rec),
    .pop_i   (w_pop),
    .rdata_o (w_rd_rec),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (count_o)
  );

  assign evt_if.evt_valid = !w_empty;
  assign evt_if.evt_ts    = w_rd_rec.ts;
  assign evt_if.evt_bits  = w_rd_rec.bits;
  assign overflow_o       = overflow_q;

`ifdef EVTCAP_DROP_COUNT_EN
  logic [EVTCAP_DROP_W-1:0] dropped_q, dropped_d;
  logic [EVTCAP_DROP_W-1:0] w_drop_base;
  logic                     w_drop;

  // The record that trips the overflow counts, as does every later change while still enabled.
  always_comb begin
    w_drop_base = (state_q == IDLE && en_q) ? '0 : dropped_q;
    w_drop      = w_lost || (state_q == OVERFLOW && en_q && w_change);
    dropped_d   = w_drop_base;
    if (w_drop && (w_drop_base != {EVTCAP_DROP_W{1'b1}})) begin
      dropped_d = w_drop_base + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      dropped_q <= '0;
    end else begin
      dropped_q <= dropped_d;
    end
  end

  assign dropped_o = dropped_q;
`endif

endmodule
`default_nettype wire
